// File: rtl/weight_seq_ctrl.sv
// weight_seq_ctrl: per-neuron weight memory sequencer.
// Owns both ports of one neuron's weight memory. The config side filters the
// global weight stream for this layer/neuron and writes matching beats to
// auto-incrementing addresses. The inference side turns each accepted input
// sample into a weight read and emits (x, w) pairs for the MAC.
// Optional build macro WSEQ_PRETRAINED_EN: weights come from the memory's init
// file, the config stream is drained without writes, and load_done pulses once
// after reset.
module weight_seq_ctrl #(
  parameter int NUM_WEIGHT = 784,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [7:0]            cfg_layer,
  input  logic [7:0]            cfg_neuron,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  load_done,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic [DATA_WIDTH-1:0] mem_win,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_wout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_w,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [7:0]            MY_LAYER  = 8'(LAYER_NO);
  localparam logic [7:0]            MY_NEURON = 8'(NEURON_NO);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic                  load_done_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic [DATA_WIDTH-1:0] out_x_r;

  logic                  cfg_ready_s;
  logic                  x_ready_s;
  logic                  cfg_hit_s;
  logic                  x_acc_s;
  logic                  wlast_s;
  logic                  rlast_s;

`ifdef WSEQ_PRETRAINED_EN
  logic                  boot_r;

  // Arm a single load_done pulse for the first cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_r <= 1'b1;
    end else begin
      boot_r <= 1'b0;
    end
  end
`endif

  // Handshake readiness and accept decisions for the current cycle.
  always_comb begin
    cfg_ready_s = 1'b0;
    x_ready_s   = 1'b0;
    cfg_hit_s   = 1'b0;
`ifdef WSEQ_PRETRAINED_EN
    // Config stream is drained and ignored; samples only wait on LOAD,
    // which this build never enters.
    cfg_ready_s = 1'b1;
    x_ready_s   = (state_r != LOAD);
    cfg_hit_s   = 1'b0;
`else
    // Config has priority in IDLE: a sample is stalled while cfg_valid is up.
    cfg_ready_s = (state_r != RUN);
    x_ready_s   = (state_r == RUN) || ((state_r == IDLE) && !cfg_valid);
    cfg_hit_s   = cfg_valid && cfg_ready_s &&
                  (cfg_layer == MY_LAYER) && (cfg_neuron == MY_NEURON);
`endif
    x_acc_s = x_valid && x_ready_s;
    wlast_s = (wptr_r == LAST_ADDR);
    rlast_s = (rptr_r == LAST_ADDR);
  end

  assign cfg_ready = cfg_ready_s;
  assign x_ready   = x_ready_s;
  assign mem_ren   = x_acc_s;
  assign mem_radd  = rptr_r;
`ifdef WSEQ_PRETRAINED_EN
  assign mem_wen   = 1'b0;
  assign mem_wadd  = ADDR_ZERO;
  assign mem_win   = {DATA_WIDTH{1'b0}};
`else
  assign mem_wen   = cfg_hit_s;
  assign mem_wadd  = wptr_r;
  assign mem_win   = cfg_data;
`endif

  // Sequencer state, write/read pointers and the registered MAC-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wptr_r      <= ADDR_ZERO;
      rptr_r      <= ADDR_ZERO;
      load_done_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_x_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      // The weight for an accepted sample arrives one cycle later, so the
      // sample and its flags are delayed by one register to line up with it.
      out_valid_r <= x_acc_s;
      out_last_r  <= x_acc_s && rlast_s;
      if (x_acc_s) begin
        out_x_r <= x_data;
      end
`ifdef WSEQ_PRETRAINED_EN
      load_done_r <= boot_r;
`else
      load_done_r <= cfg_hit_s && wlast_s;
`endif
      case (state_r)
        IDLE: begin
          if (cfg_hit_s) begin
            if (wlast_s) begin
              wptr_r  <= ADDR_ZERO;
              state_r <= IDLE;
            end else begin
              wptr_r  <= wptr_r + ADDR_ONE;
              state_r <= LOAD;
            end
          end else if (x_acc_s) begin
            if (rlast_s) begin
              rptr_r  <= ADDR_ZERO;
              state_r <= IDLE;
            end else begin
              rptr_r  <= rptr_r + ADDR_ONE;
              state_r <= RUN;
            end
          end
        end
        LOAD: begin
          if (cfg_hit_s) begin
            if (wlast_s) begin
              wptr_r  <= ADDR_ZERO;
              state_r <= IDLE;
            end else begin
              wptr_r  <= wptr_r + ADDR_ONE;
              state_r <= LOAD;
            end
          end
        end
        RUN: begin
          if (x_acc_s) begin
            if (rlast_s) begin
              rptr_r  <= ADDR_ZERO;
              state_r <= IDLE;
            end else begin
              rptr_r  <= rptr_r + ADDR_ONE;
              state_r <= RUN;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign load_done = load_done_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_x     = out_x_r;
  assign out_w     = mem_wout;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed testbench for weight_seq_ctrl (NUM_WEIGHT=4, LAYER_NO=1, NEURON_NO=2).
// Includes a behavioural weight memory with one-cycle registered reads.
`timescale 1ns/1ps
module tb_weight_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_layer;
  logic [7:0]  cfg_neuron;
  logic [15:0] cfg_data;
  logic        load_done;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] x_data;
  logic        mem_wen;
  logic [9:0]  mem_wadd;
  logic [15:0] mem_win;
  logic        mem_ren;
  logic [9:0]  mem_radd;
  logic [15:0] mem_wout;
  logic        out_valid;
  logic [15:0] out_x;
  logic [15:0] out_w;
  logic        out_last;

  int checks;
  int failures;

  logic [15:0] mem [0:1023];

  weight_seq_ctrl #(
    .NUM_WEIGHT(4), .LAYER_NO(1), .NEURON_NO(2), .ADDR_WIDTH(10), .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .cfg_data(cfg_data), .load_done(load_done),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .mem_wen(mem_wen), .mem_wadd(mem_wadd), .mem_win(mem_win),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_wout(mem_wout),
    .out_valid(out_valid), .out_x(out_x), .out_w(out_w), .out_last(out_last)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Weight memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_wadd] <= mem_win;
    if (mem_ren) mem_wout <= mem[mem_radd];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (out_x !== 16'h0000) begin failures++; $display("FAIL rst_out_x got=%h exp=0000", out_x); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (x_ready !== 1'b1) begin failures++; $display("FAIL rst_x_ready got=%b exp=1", x_ready); end
    checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b%b exp=00", mem_wen, mem_ren); end
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", load_done); end
  endtask

  // Four matching beats with data base+0..base+3; expects writes at wadd 0..3.
  task automatic load_four(input logic [15:0] base, input string tag);
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      e = base + 16'(i);
      cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd2; cfg_data = e;
      #1;
      checks++; if (mem_wen !== 1'b1) begin failures++; $display("FAIL %s_wen[%0d] got=%b exp=1", tag, i, mem_wen); end
      checks++; if (mem_wadd !== 10'(i)) begin failures++; $display("FAIL %s_wadd[%0d] got=%0d exp=%0d", tag, i, mem_wadd, i); end
      checks++; if (mem_win !== e) begin failures++; $display("FAIL %s_win[%0d] got=%h exp=%h", tag, i, mem_win, e); end
      checks++; if (x_ready !== 1'b0) begin failures++; $display("FAIL %s_x_stall[%0d] got=%b exp=0", tag, i, x_ready); end
      checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL %s_early_done[%0d] got=%b exp=0", tag, i, load_done); end
      tick();
    end
    cfg_valid = 1'b0;
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", tag, load_done); end
    #1;
    checks++; if (x_ready !== 1'b1) begin failures++; $display("FAIL %s_idle_x_ready got=%b exp=1", tag, x_ready); end
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", tag, load_done); end
  endtask

  // Four back-to-back samples base+0..3; weights expected wbase+0..3.
  task automatic run_four(input logic [15:0] base, input logic [15:0] wbase, input string tag);
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      e = base + 16'(i);
      x_valid = 1'b1; x_data = e;
      #1;
      checks++; if (mem_ren !== 1'b1) begin failures++; $display("FAIL %s_ren[%0d] got=%b exp=1", tag, i, mem_ren); end
      checks++; if (mem_radd !== 10'(i)) begin failures++; $display("FAIL %s_radd[%0d] got=%0d exp=%0d", tag, i, mem_radd, i); end
      checks++; if (cfg_ready !== (i == 0)) begin failures++; $display("FAIL %s_cfg_ready[%0d] got=%b exp=%b", tag, i, cfg_ready, (i == 0)); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_out_valid[%0d] got=%b exp=1", tag, i, out_valid); end
      checks++; if (out_x !== e) begin failures++; $display("FAIL %s_out_x[%0d] got=%h exp=%h", tag, i, out_x, e); end
      checks++; if (out_w !== wbase + 16'(i)) begin failures++; $display("FAIL %s_out_w[%0d] got=%h exp=%h", tag, i, out_w, wbase + 16'(i)); end
      checks++; if (out_last !== (i == 3)) begin failures++; $display("FAIL %s_out_last[%0d] got=%b exp=%b", tag, i, out_last, (i == 3)); end
    end
    x_valid = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL %s_end_cfg_ready got=%b exp=1", tag, cfg_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL %s_drop got=%b%b exp=00", tag, out_valid, out_last); end
  endtask

  task automatic test_config_load();
    load_four(16'h0011, "load");
  endtask

  task automatic test_inference();
    run_four(16'h0100, 16'h0011, "frame");
  endtask

  task automatic test_filtered();
    logic [0:3][7:0]  ly;
    logic [0:3][7:0]  nr;
    logic [0:3][15:0] dt;
    logic [0:3]       ew;
    logic [0:3][9:0]  ea;
    ly = {8'd1, 8'd1, 8'd2, 8'd1};
    nr = {8'd3, 8'd2, 8'd2, 8'd2};
    dt = {16'hDEAD, 16'h0011, 16'hBEEF, 16'h0012};
    ew = 4'b0101;
    ea = {10'd0, 10'd0, 10'd0, 10'd1};
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_layer = ly[i]; cfg_neuron = nr[i]; cfg_data = dt[i];
      #1;
      checks++; if (mem_wen !== ew[i]) begin failures++; $display("FAIL filt_wen[%0d] got=%b exp=%b", i, mem_wen, ew[i]); end
      if (ew[i]) begin
        checks++; if (mem_wadd !== ea[i]) begin failures++; $display("FAIL filt_wadd[%0d] got=%0d exp=%0d", i, mem_wadd, ea[i]); end
      end
      tick();
    end
    cfg_valid = 1'b0; x_valid = 1'b1; x_data = 16'h0999;
    #1;
    checks++; if (x_ready !== 1'b0) begin failures++; $display("FAIL filt_x_blocked got=%b exp=0", x_ready); end
    checks++; if (mem_ren !== 1'b0) begin failures++; $display("FAIL filt_no_ren got=%b exp=0", mem_ren); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL filt_cfg_ready got=%b exp=1", cfg_ready); end
    tick();
    x_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL filt_out_valid got=%b exp=0", out_valid); end
    for (int i = 2; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd2; cfg_data = 16'h0011 + 16'(i);
      #1;
      checks++; if (mem_wen !== 1'b1 || mem_wadd !== 10'(i)) begin failures++; $display("FAIL filt_finish[%0d] got=%b/%0d exp=1/%0d", i, mem_wen, mem_wadd, i); end
      tick();
    end
    cfg_valid = 1'b0;
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL filt_done got=%b exp=1", load_done); end
    tick();
  endtask

  task automatic test_gapped_contention();
    logic [0:11]      xv;
    logic [0:11]      cv;
    logic [0:11]      exr;
    logic [0:11]      ecr;
    logic [0:11]      ern;
    logic [0:11][1:0] era;
    logic [15:0]      e;
    xv  = 12'b101011111110;
    cv  = 12'b001111100000;
    exr = 12'b111111011111;
    ecr = 12'b100000110001;
    ern = 12'b101011011110;
    era = {2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 12; i++) begin
      e = 16'h0200 + 16'(i);
      cfg_valid = cv[i]; cfg_layer = (i == 6) ? 8'd2 : 8'd1; cfg_neuron = 8'd2; cfg_data = 16'h0011;
      x_valid = xv[i]; x_data = e;
      #1;
      checks++; if (x_ready !== exr[i]) begin failures++; $display("FAIL gap_x_ready[%0d] got=%b exp=%b", i, x_ready, exr[i]); end
      checks++; if (cfg_ready !== ecr[i]) begin failures++; $display("FAIL gap_cfg_ready[%0d] got=%b exp=%b", i, cfg_ready, ecr[i]); end
      checks++; if (mem_ren !== ern[i]) begin failures++; $display("FAIL gap_ren[%0d] got=%b exp=%b", i, mem_ren, ern[i]); end
      checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL gap_wen[%0d] got=%b exp=0", i, mem_wen); end
      if (ern[i]) begin
        checks++; if (mem_radd !== 10'(era[i])) begin failures++; $display("FAIL gap_radd[%0d] got=%0d exp=%0d", i, mem_radd, era[i]); end
      end
      tick();
      checks++; if (out_valid !== ern[i]) begin failures++; $display("FAIL gap_out_valid[%0d] got=%b exp=%b", i, out_valid, ern[i]); end
      checks++; if (out_last !== (ern[i] && era[i] == 2'd3)) begin failures++; $display("FAIL gap_out_last[%0d] got=%b exp=%b", i, out_last, (ern[i] && era[i] == 2'd3)); end
      if (ern[i]) begin
        checks++; if (out_x !== e) begin failures++; $display("FAIL gap_out_x[%0d] got=%h exp=%h", i, out_x, e); end
        checks++; if (out_w !== 16'h0011 + 16'(era[i])) begin failures++; $display("FAIL gap_out_w[%0d] got=%h exp=%h", i, out_w, 16'h0011 + 16'(era[i])); end
      end
    end
    cfg_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd2; cfg_data = 16'h0055 + 16'(i);
      #1;
      checks++; if (mem_wen !== 1'b1 || mem_wadd !== 10'(i)) begin failures++; $display("FAIL rml_write[%0d] got=%b/%0d exp=1/%0d", i, mem_wen, mem_wadd, i); end
      tick();
    end
    cfg_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rml_done_in_rst got=%b exp=0", load_done); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (x_ready !== 1'b1) begin failures++; $display("FAIL rml_idle got=%b exp=1", x_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rml_no_done[%0d] got=%b exp=0", i, load_done); end
    end
    load_four(16'h0021, "reload");
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1; x_data = 16'h0300 + 16'(i);
      #1;
      checks++; if (mem_radd !== 10'(i)) begin failures++; $display("FAIL rmr_radd[%0d] got=%0d exp=%0d", i, mem_radd, i); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmr_out_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    x_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rmr_rst_out got=%b%b exp=00", out_valid, out_last); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rmr_idle got=%b exp=1", cfg_ready); end
    tick();
    run_four(16'h0400, 16'h0021, "rerun");
  endtask

  task automatic test_pretrained();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    tick();
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL pre_done_in_rst got=%b exp=0", load_done); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (load_done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL pre_done_pulses got=%0d exp=1", pulses); end
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd2; cfg_data = 16'h7777;
      x_valid = 1'b1; x_data = 16'h0500 + 16'(i);
      #1;
      checks++; if (cfg_ready !== 1'b1 || mem_wen !== 1'b0) begin failures++; $display("FAIL pre_cfg[%0d] got=%b/%b exp=1/0", i, cfg_ready, mem_wen); end
      checks++; if (mem_ren !== 1'b1 || mem_radd !== 10'(i)) begin failures++; $display("FAIL pre_read[%0d] got=%b/%0d exp=1/%0d", i, mem_ren, mem_radd, i); end
      tick();
      checks++; if (out_w !== 16'h0011 + 16'(i)) begin failures++; $display("FAIL pre_out_w[%0d] got=%h exp=%h", i, out_w, 16'h0011 + 16'(i)); end
      checks++; if (out_last !== (i == 3)) begin failures++; $display("FAIL pre_out_last[%0d] got=%b exp=%b", i, out_last, (i == 3)); end
    end
    cfg_valid = 1'b0; x_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_layer = 8'd0; cfg_neuron = 8'd0; cfg_data = 16'h0000;
    x_valid = 1'b0; x_data = 16'h0000;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
`ifdef WSEQ_PRETRAINED_EN
    for (int i = 0; i < 4; i++) mem[i] = 16'h0011 + 16'(i);
    test_pretrained();
`else
    test_reset();
    test_config_load();
    test_inference();
    test_filtered();
    test_gapped_contention();
    test_reset_mid_load();
    test_reset_mid_run();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_seq_ctrl.md
Name: weight_seq_ctrl

Overview:
- Per-neuron controller that owns both ports of one neuron's weight memory instance.
- Config side: accepts the global weight-config stream, keeps beats addressed to its own layer/neuron, and writes them to auto-incrementing addresses.
- Inference side: for each accepted input sample, issues the matching weight read and emits (x, w) pairs aligned for the neuron's MAC, with a frame-last flag.
- Loading and inference are never active at the same time.

Parameters:
- NUM_WEIGHT, 784, weights per neuron; frame length in samples.
- LAYER_NO, 1, layer number this neuron answers to on the config bus.
- NEURON_NO, 0, neuron number this neuron answers to on the config bus.
- ADDR_WIDTH, 10, memory address width; must satisfy 2**ADDR_WIDTH >= NUM_WEIGHT.
- DATA_WIDTH, 16, fixed-point weight/sample width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when cfg_valid && cfg_ready.
- cfg_layer  in  8  target layer of the beat.
- cfg_neuron  in  8  target neuron of the beat.
- cfg_data  in  DATA_WIDTH  weight value.
- load_done  out  1  one-cycle pulse when the full weight set has been written.
- x_valid  in  1  input sample valid.
- x_ready  out  1  input sample accepted when x_valid && x_ready.
- x_data  in  DATA_WIDTH  input sample.
- mem_wen  out  1  memory write enable.
- mem_wadd  out  ADDR_WIDTH  memory write address.
- mem_win  out  DATA_WIDTH  memory write data.
- mem_ren  out  1  memory read enable.
- mem_radd  out  ADDR_WIDTH  memory read address.
- mem_wout  in  DATA_WIDTH  memory read data, registered in the memory, one cycle latency.
- out_valid  out  1  (out_x, out_w) pair valid.
- out_x  out  DATA_WIDTH  sample aligned to its weight.
- out_w  out  DATA_WIDTH  weight; direct pass-through of mem_wout.
- out_last  out  1  marks the pair for address NUM_WEIGHT-1.

Behaviour:
- Reset: state IDLE, wptr=0, rptr=0. out_valid, out_last, out_x, load_done all 0. Memory contents are untouched.
- States: IDLE, LOAD, RUN.
- Match: a config beat matches when cfg_layer==LAYER_NO && cfg_neuron==NEURON_NO.
- Ready signals:
  - cfg_ready = (state != RUN).
  - x_ready = (state==RUN) || (state==IDLE && !cfg_valid). Config has priority in IDLE; x is stalled in any cycle where cfg_valid is high.
- Accepted beat that does not match: consumed, no write, no state change.
- Accepted matching beat:
  - Same cycle, combinationally: mem_wen=1, mem_wadd=wptr, mem_win=cfg_data.
  - If wptr==NUM_WEIGHT-1: wptr<=0, load_done<=1 for the next cycle, state<=IDLE.
  - Otherwise: wptr<=wptr+1, state<=LOAD.
- Accepted sample:
  - Same cycle, combinationally: mem_ren=1, mem_radd=rptr.
  - Next cycle: out_valid=1, out_x=x_data (registered), out_w=mem_wout, out_last=(rptr was NUM_WEIGHT-1).
  - If rptr==NUM_WEIGHT-1: rptr<=0, state<=IDLE. Otherwise: rptr<=rptr+1, state<=RUN.
- When not accepting: mem_wen=0 and mem_ren=0. out_valid and out_last drop to 0 the cycle after a non-accept cycle.
- Throughput: one sample per cycle in RUN; gaps in x_valid are allowed. No backpressure from the output side; the MAC always consumes.
- LOAD blocks x entirely until the last weight is written. RUN blocks cfg entirely until the last sample is accepted.
- Reset mid-LOAD: the partial load is abandoned, load_done is not pulsed, and already-written words remain. Reset mid-RUN: the frame is abandoned and no out_last is produced.
- NUM_WEIGHT==1: every accepted matching beat pulses load_done and every accepted sample is last; the FSM stays in IDLE.

Optional Feature:
- Macro: WSEQ_PRETRAINED_EN.
- Defined: weights come from the memory's init file.
  - cfg_ready tied 1, so the config stream drains.
  - mem_wen tied 0; mem_wadd and mem_win tied 0.
  - load_done pulses once, in the first cycle after rst deasserts.
  - LOAD state is unreachable; x_ready = (state != LOAD), with no config priority.
- Undefined: behaviour as above.

Test Plan (NUM_WEIGHT=4, LAYER_NO=1, NEURON_NO=2):
- Config load: 4 matching beats 0x0011..0x0014, back-to-back → mem_wen at wadd 0,1,2,3 with those data; load_done high exactly one cycle after the 4th beat; state returns to IDLE.
- Filtered beats: beats for neuron 3 and for layer 2, interleaved with 2 matching beats → only 2 writes (wadd 0,1); state LOAD; x_ready=0 while x_valid=1.
- Inference frame: after load, samples 0x0100..0x0103 back-to-back → mem_radd 0,1,2,3; out_valid one cycle later on each; out_x/out_w pairs (0x0100,0x0011)…(0x0103,0x0014); out_last only on the 4th; cfg_ready=0 during RUN.
- Gapped frame plus contention: x_valid with gaps, and cfg_valid asserted mid-frame → cfg held off until the frame ends. In IDLE with cfg_valid and x_valid both high → cfg accepted, x stalled one cycle.
- Reset mid-LOAD after 2 writes → no load_done; wptr=0; a new 4-beat load writes from wadd 0. Reset mid-RUN after 2 samples → out_valid=0; the next frame starts at radd 0.
- WSEQ_PRETRAINED_EN build: load_done pulses once after reset; config beats accepted with mem_wen=0; frame of 4 samples produces out_last on the 4th.
